// File: rtl/edge_det_pkg.sv
// Shared constants and helpers for edge_event_detector.
// EDGE_DET_SYNC_EN selects the synchronised input path, which changes the prime count.
package edge_det_pkg;

   localparam int SYNC_STAGES = 2;

`ifdef EDGE_DET_SYNC_EN
   // Synchronizer flush zeros must drain before `last` holds a real sample.
   localparam int PRIME_CNT = SYNC_STAGES + 1;
`else
   localparam int PRIME_CNT = 1;
`endif

   // Callers zero-extend their vector to this width; channel counts above it are not supported.
   localparam int POP_MAX_W = 256;

   function automatic logic [31:0] popcount(input logic [POP_MAX_W-1:0] v);
      logic [31:0] n;
      n = '0;
      for (int i = 0; i < POP_MAX_W; i++) begin
         n = n + {31'd0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/edge_det_sync.sv
// WIDTH-wide N-stage flop synchronizer with asynchronous active-low reset to 0.
// Latency is STAGES cycles; no backpressure.
module edge_det_sync #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             i_clk,
   input  logic             i_aresetn,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [STAGES-1:0][WIDTH-1:0] r_stage;

   always_ff @(posedge i_clk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         r_stage <= '0;
      end else begin
         r_stage[0] <= i_d;
         for (int i = 1; i < STAGES; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/edge_event_detector.sv
// Per-bit rise/fall edge detector with sticky flags, interrupt and saturating event counter.
// Pulse 1 cycle after sampling (3 with EDGE_DET_SYNC_EN); no backpressure, events never stall.
module edge_event_detector
   import edge_det_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             aresetn,
   input  logic [WIDTH-1:0] in,
   input  logic [WIDTH-1:0] rise_en,
   input  logic [WIDTH-1:0] fall_en,
   input  logic [WIDTH-1:0] clr,
   input  logic             cnt_clr,
   output logic [WIDTH-1:0] pulse,
   output logic [WIDTH-1:0] sticky,
   output logic             irq,
   output logic [CNT_W-1:0] count
);

   localparam int SUM_W = CNT_W + $clog2(WIDTH + 1);
   localparam int PC_W  = $clog2(PRIME_CNT + 1);
   localparam logic [SUM_W-1:0] CNT_MAX    = SUM_W'({CNT_W{1'b1}});
   localparam logic [PC_W-1:0]  PRIME_DONE = PC_W'(PRIME_CNT);

   logic [WIDTH-1:0]     w_s;
   logic [WIDTH-1:0]     w_ev;
   logic [WIDTH-1:0]     w_sticky_nxt;
   logic                 w_primed;
   logic [POP_MAX_W-1:0] w_ev_ext;
   logic [SUM_W-1:0]     w_pop;
   logic [SUM_W-1:0]     w_base;
   logic [SUM_W-1:0]     w_sum;

   logic [WIDTH-1:0]     r_last;
   logic [WIDTH-1:0]     r_pulse;
   logic [WIDTH-1:0]     r_sticky;
   logic                 r_irq;
   logic [CNT_W-1:0]     r_count;
   logic [PC_W-1:0]      r_prime_cnt;

`ifdef EDGE_DET_SYNC_EN
   edge_det_sync #(
      .WIDTH  (WIDTH),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .i_clk     (clk),
      .i_aresetn (aresetn),
      .i_d       (in),
      .o_q       (w_s)
   );
`else
   assign w_s = in;
`endif

   assign w_primed     = (r_prime_cnt == PRIME_DONE);
   assign w_ev         = w_primed ? ((w_s & ~r_last & rise_en) | (~w_s & r_last & fall_en)) : '0;
   assign w_sticky_nxt = w_ev | (r_sticky & ~clr);

   // Sum is wide enough for a full popcount on top of a saturated count.
   assign w_ev_ext = POP_MAX_W'(w_ev);
   assign w_pop    = SUM_W'(popcount(w_ev_ext));
   assign w_base   = cnt_clr ? '0 : SUM_W'(r_count);
   assign w_sum    = w_base + w_pop;

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_last      <= '0;
         r_pulse     <= '0;
         r_sticky    <= '0;
         r_irq       <= 1'b0;
         r_count     <= '0;
         r_prime_cnt <= '0;
      end else begin
         r_last   <= w_s;
         r_pulse  <= w_ev;
         r_sticky <= w_sticky_nxt;
         r_irq    <= |w_sticky_nxt;
         r_count  <= (w_sum > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(w_sum);
         if (!w_primed) begin
            r_prime_cnt <= r_prime_cnt + PC_W'(1);
         end
      end
   end

   assign pulse  = r_pulse;
   assign sticky = r_sticky;
   assign irq    = r_irq;
   assign count  = r_count;

endmodule

// File: tb/tb_edge_event_detector.sv
// Bench for edge_event_detector: table-driven vectors with a scoreboard queue of expected outputs.
module tb_edge_event_detector;

`ifdef EDGE_DET_SYNC_EN
   localparam int PRIME = 3;
`else
   localparam int PRIME = 1;
`endif

   typedef struct {
      logic [7:0] in_v;
      logic [7:0] re;
      logic [7:0] fe;
      logic [7:0] clr_v;
      logic       cc;
      logic [7:0] pulse_e;
      logic [7:0] sticky_e;
      logic       irq_e;
      logic [7:0] count_e;
   } vec_t;

   typedef struct {
      logic [7:0] pulse_e;
      logic [7:0] sticky_e;
      logic       irq_e;
      logic [7:0] count_e;
   } exp_t;

   logic       clk = 1'b0;
   logic       aresetn = 1'b0;
   logic [7:0] t_in = '0;
   logic [7:0] t_rise_en = '0;
   logic [7:0] t_fall_en = '0;
   logic [7:0] t_clr = '0;
   logic       t_cnt_clr = 1'b0;
   logic [7:0] t_pulse;
   logic [7:0] t_sticky;
   logic       t_irq;
   logic [7:0] t_count;

   int   n_tests = 0;
   int   n_fail = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   edge_event_detector #(.WIDTH(8), .CNT_W(8)) dut (
      .clk     (clk),
      .aresetn (aresetn),
      .in      (t_in),
      .rise_en (t_rise_en),
      .fall_en (t_fall_en),
      .clr     (t_clr),
      .cnt_clr (t_cnt_clr),
      .pulse   (t_pulse),
      .sticky  (t_sticky),
      .irq     (t_irq),
      .count   (t_count)
   );

   function automatic vec_t mk(input logic [7:0] i, input logic [7:0] re, input logic [7:0] fe,
                               input logic [7:0] c, input logic cc, input logic [7:0] p,
                               input logic [7:0] s, input logic q, input logic [7:0] n);
      vec_t v;
      v.in_v = i; v.re = re; v.fe = fe; v.clr_v = c; v.cc = cc;
      v.pulse_e = p; v.sticky_e = s; v.irq_e = q; v.count_e = n;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic step(input vec_t v, input string tag);
      exp_t e;
      @(negedge clk);
      t_in = v.in_v; t_rise_en = v.re; t_fall_en = v.fe; t_clr = v.clr_v; t_cnt_clr = v.cc;
      e.pulse_e = v.pulse_e; e.sticky_e = v.sticky_e; e.irq_e = v.irq_e; e.count_e = v.count_e;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         n_tests++; n_fail++;
         $display("FAIL %s scoreboard: queue empty", tag);
      end else begin
         e = sb_q.pop_front();
         check({tag, " pulse"},  32'(t_pulse),  32'(e.pulse_e));
         check({tag, " sticky"}, 32'(t_sticky), 32'(e.sticky_e));
         check({tag, " irq"},    32'(t_irq),    32'(e.irq_e));
         check({tag, " count"},  32'(t_count),  32'(e.count_e));
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, " pulse"},  32'(t_pulse),  32'h0);
      check({tag, " sticky"}, 32'(t_sticky), 32'h0);
      check({tag, " irq"},    32'(t_irq),    32'h0);
      check({tag, " count"},  32'(t_count),  32'h0);
   endtask

   task automatic do_reset(input logic [7:0] v);
      @(negedge clk);
      aresetn = 1'b0;
      t_in = v; t_rise_en = 8'hFF; t_fall_en = 8'hFF; t_clr = '0; t_cnt_clr = 1'b0;
      #1;
      check_zero("reset");
      @(negedge clk);
      aresetn = 1'b1;
      for (int i = 0; i < PRIME; i++) begin
         step(mk(v, 8'hFF, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00), "prime");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[17];

      // Held nonzero input across reset release must never look like an edge.
      do_reset(8'hFF);
      for (int i = 0; i < 10; i++) begin
         step(mk(8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00), "hold_ff");
      end

`ifdef EDGE_DET_SYNC_EN
      do_reset(8'h00);
      step(mk(8'h01, 8'hFF, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00), "sync_c1");
      step(mk(8'h01, 8'hFF, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00), "sync_c2");
      step(mk(8'h01, 8'hFF, 8'hFF, 8'h00, 1'b0, 8'h01, 8'h01, 1'b1, 8'h01), "sync_c3");
      step(mk(8'h01, 8'hFF, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h01, 1'b1, 8'h01), "sync_c4");
`else
      tbl[0]  = mk(8'h01, 8'hFF, 8'hFF, 8'h00, 1'b0, 8'h01, 8'h01, 1'b1, 8'd1);
      tbl[1]  = mk(8'h01, 8'hFF, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h01, 1'b1, 8'd1);
      tbl[2]  = mk(8'h01, 8'hFF, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h01, 1'b1, 8'd1);
      tbl[3]  = mk(8'h01, 8'hFF, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h01, 1'b1, 8'd1);
      tbl[4]  = mk(8'h00, 8'hFF, 8'hFF, 8'h00, 1'b0, 8'h01, 8'h01, 1'b1, 8'd2);
      tbl[5]  = mk(8'h00, 8'hFF, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h01, 1'b1, 8'd2);
      tbl[6]  = mk(8'h00, 8'h0F, 8'hF0, 8'hFF, 1'b1, 8'h00, 8'h00, 1'b0, 8'd0);
      tbl[7]  = mk(8'hFF, 8'h0F, 8'hF0, 8'h00, 1'b0, 8'h0F, 8'h0F, 1'b1, 8'd4);
      tbl[8]  = mk(8'h00, 8'h0F, 8'hF0, 8'h00, 1'b0, 8'hF0, 8'hFF, 1'b1, 8'd8);
      tbl[9]  = mk(8'hFF, 8'h00, 8'hFF, 8'h00, 1'b0, 8'h00, 8'hFF, 1'b1, 8'd8);
      tbl[10] = mk(8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b0, 8'h00, 8'hFF, 1'b1, 8'd8);
      tbl[11] = mk(8'h00, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h00, 8'hFF, 1'b1, 8'd8);
      tbl[12] = mk(8'h08, 8'hFF, 8'hFF, 8'hFF, 1'b0, 8'h08, 8'h08, 1'b1, 8'd9);
      tbl[13] = mk(8'h08, 8'hFF, 8'hFF, 8'h08, 1'b0, 8'h00, 8'h00, 1'b0, 8'd9);
      tbl[14] = mk(8'h00, 8'hFF, 8'hFF, 8'h00, 1'b0, 8'h08, 8'h08, 1'b1, 8'd10);
      tbl[15] = mk(8'h08, 8'hFF, 8'hFF, 8'h00, 1'b0, 8'h08, 8'h08, 1'b1, 8'd11);
      tbl[16] = mk(8'h00, 8'hFF, 8'hFF, 8'h00, 1'b0, 8'h08, 8'h08, 1'b1, 8'd12);

      do_reset(8'h00);
      for (int i = 0; i < 17; i++) begin
         step(tbl[i], $sformatf("vec%0d", i));
      end

      // Toggle all bits every cycle to walk the counter up to the saturation boundary.
      do_reset(8'h00);
      for (int k = 1; k <= 31; k++) begin
         step(mk((k % 2) ? 8'hFF : 8'h00, 8'hFF, 8'hFF, 8'h00, 1'b0,
                 8'hFF, 8'hFF, 1'b1, 8'(8 * k)), "ramp");
      end
      step(mk(8'h00, 8'hFF, 8'h7F, 8'h00, 1'b0, 8'h7F, 8'hFF, 1'b1, 8'd255), "sat_exact");
      step(mk(8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b0, 8'hFF, 8'hFF, 1'b1, 8'd255), "sat_hold1");
      step(mk(8'h00, 8'hFF, 8'hFF, 8'h00, 1'b0, 8'hFF, 8'hFF, 1'b1, 8'd255), "sat_hold2");
      step(mk(8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b1, 8'hFF, 8'hFF, 1'b1, 8'd8),   "cnt_clr_ev");
      step(mk(8'h00, 8'hFF, 8'hFF, 8'h00, 1'b0, 8'hFF, 8'hFF, 1'b1, 8'd16),  "after_clr");
`endif

      // Asynchronous reset between clock edges must clear outputs at once.
      @(posedge clk);
      #3;
      aresetn = 1'b0;
      #1;
      check_zero("async_rst");
      do_reset(8'hFF);
      step(mk(8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00), "reprime");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
